// File: rtl/cache_bus_pkg.sv
// Shared C1/C2 bus definitions and line geometry used by the cache and main memory.
package cache_bus_pkg;

  localparam int BUS_SIZE          = 16;
  localparam int MEM_ADDR_SIZE     = 19;
  localparam int CACHE_OFFSET_SIZE = 4;
  localparam int CACHE_LINE_SIZE   = 16;

  localparam int BEATS       = CACHE_LINE_SIZE * 8 / BUS_SIZE;
  localparam int LINE_ADDR_W = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
  localparam int LINE_W      = CACHE_LINE_SIZE * 8;
  localparam int BEAT_W      = $clog2(BEATS);
  localparam int BUS_LOG2    = $clog2(BUS_SIZE);

  // CPU-to-cache command encodings
  localparam logic [2:0] C1_NOP             = 3'd0;
  localparam logic [2:0] C1_READ8           = 3'd1;
  localparam logic [2:0] C1_READ16          = 3'd2;
  localparam logic [2:0] C1_READ32          = 3'd3;
  localparam logic [2:0] C1_INVALIDATE_LINE = 3'd4;
  localparam logic [2:0] C1_WRITE8          = 3'd5;
  localparam logic [2:0] C1_WRITE16         = 3'd6;
  localparam logic [2:0] C1_WRITE32         = 3'd7;
  localparam logic [2:0] C1_RESPONSE        = 3'd7;

  // Cache-to-memory command encodings
  localparam logic [1:0] C2_NOP      = 2'd0;
  localparam logic [1:0] C2_RESPONSE = 2'd1;
  localparam logic [1:0] C2_READ     = 2'd2;
  localparam logic [1:0] C2_WRITE    = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECV_WR = 3'd1,
    WAIT    = 3'd2,
    SEND_RD = 3'd3,
    RESP_WR = 3'd4
  } mem_state_e;

  // Beat i of a line is bytes {2i+1, 2i}, little-endian.
  function automatic logic [BUS_SIZE-1:0] get_beat(input logic [LINE_W-1:0] line,
                                                   input logic [BEAT_W-1:0] idx);
    return line[{idx, {BUS_LOG2{1'b0}}} +: BUS_SIZE];
  endfunction

endpackage

// File: rtl/mem_line_store.sv
// Line-wide main-memory array: one synchronous write port, one combinational read port.
module mem_line_store
  import cache_bus_pkg::*;
(
  input  logic                   clk,
  input  logic [LINE_ADDR_W-1:0] line_addr,
  input  logic [LINE_W-1:0]      wr_line,
  input  logic                   we,
  output logic [LINE_W-1:0]      rd_line
);

  logic [LINE_W-1:0] mem [2**LINE_ADDR_W];

  // Commit a whole line when the controller has received all beats.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[line_addr] <= wr_line;
    end
  end

  assign rd_line = mem[line_addr];

endmodule

// File: rtl/mem_ctrl.sv
// Main-memory controller on the C2 bus: receives/sends 16-byte lines as 8 beats with a
// fixed response latency, driving the shared buses only while it owns them.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | bus released, sampling mem_command every edge
//   RECV_WR | cache is streaming write beats 1..7; line committed at beat 7
//   WAIT    | memory owns the bus, drives C2_NOP until edge LATENCY
//   SEND_RD | drives C2_RESPONSE with read beats 0..7
//   RESP_WR | drives C2_RESPONSE for one cycle to acknowledge a write
module mem_ctrl
  import cache_bus_pkg::*;
#(
  parameter int LATENCY = 100
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LINE_ADDR_W-1:0] mem_address,
  inout  wire  [BUS_SIZE-1:0]    mem_data,
  inout  wire  [1:0]             mem_command,
  output logic                   busy
);

  localparam int CNT_W = $clog2(LATENCY + BEATS + 1);
  // cnt holds the number of edges since the command edge; each compare
  // fires on the edge one past the stored value.
  localparam logic [CNT_W-1:0] RECV_TC = CNT_W'(BEATS - 2);
  localparam logic [CNT_W-1:0] WAIT_TC = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] SEND_TC = CNT_W'(LATENCY + BEATS - 1);
  localparam logic [CNT_W-1:0] LAT_C   = CNT_W'(LATENCY);

  mem_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [LINE_ADDR_W-1:0] addr_q;
  logic                   op_wr_q;
  logic [LINE_W-1:0]      buf_q;

  logic                   accept_rd, accept_wr;
  logic                   buf_we;
  logic [BEAT_W-1:0]      buf_idx;
  logic                   store_we;
  logic                   cmd_oe, data_oe;
  logic [1:0]             cmd_out;
  logic [BUS_SIZE-1:0]    data_out;
  logic [LINE_W-1:0]      rd_line, wr_line;
  logic [BEAT_W-1:0]      rd_idx;

  assign rd_idx  = BEAT_W'(cnt_q - LAT_C);
  // Last beat arrives on the commit edge, so it bypasses the buffer.
  assign wr_line = {mem_data, buf_q[LINE_W-BUS_SIZE-1:0]};

  mem_line_store u_store (
    .clk       (clk),
    .line_addr (addr_q),
    .wr_line   (wr_line),
    .we        (store_we & ~reset),
    .rd_line   (rd_line)
  );

  // State, counter, latched address and write assembly buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_rd || accept_wr) begin
        addr_q  <= mem_address;
        op_wr_q <= accept_wr;
      end
      if (buf_we) begin
        buf_q[{buf_idx, {BUS_LOG2{1'b0}}} +: BUS_SIZE] <= mem_data;
      end
    end
  end

  // Next-state, counter and bus-drive decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept_rd = 1'b0;
    accept_wr = 1'b0;
    buf_we    = 1'b0;
    buf_idx   = '0;
    store_we  = 1'b0;
    cmd_oe    = 1'b0;
    cmd_out   = C2_NOP;
    data_oe   = 1'b0;
    data_out  = get_beat(rd_line, rd_idx);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        case (mem_command)
          C2_READ: begin
            accept_rd = 1'b1;
            state_d   = WAIT;
          end
          C2_WRITE: begin
            accept_wr = 1'b1;
            buf_we    = 1'b1;
            state_d   = RECV_WR;
          end
          default: ;
        endcase
      end
      RECV_WR: begin
        cnt_d   = cnt_q + CNT_W'(1);
        buf_we  = 1'b1;
        buf_idx = BEAT_W'(cnt_q) + BEAT_W'(1);
        if (cnt_q == RECV_TC) begin
          store_we = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        cnt_d   = cnt_q + CNT_W'(1);
        cmd_oe  = 1'b1;
        cmd_out = C2_NOP;
        if (cnt_q == WAIT_TC) begin
          state_d = op_wr_q ? RESP_WR : SEND_RD;
        end
      end
      SEND_RD: begin
        cnt_d   = cnt_q + CNT_W'(1);
        cmd_oe  = 1'b1;
        cmd_out = C2_RESPONSE;
        data_oe = 1'b1;
        if (cnt_q == SEND_TC) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      RESP_WR: begin
        cmd_oe  = 1'b1;
        cmd_out = C2_RESPONSE;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign mem_command = cmd_oe  ? cmd_out  : 2'bzz;
  assign mem_data    = data_oe ? data_out : {BUS_SIZE{1'bz}};

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: one instance at LATENCY=100, one at the minimum LATENCY=8.
// Bus nets are pulled (data high, command low) so a released bus reads back a known value.
module tb_mem_ctrl;
  import cache_bus_pkg::*;

  localparam logic [15:0] DATA_REL = 16'hFFFF;
  localparam logic [1:0]  CMD_REL  = 2'b00;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [14:0] drv_addr    [2];
  logic [1:0]  drv_cmd     [2];
  logic        drv_cmd_oe  [2];
  logic [15:0] drv_data    [2];
  logic        drv_data_oe [2];

  tri1 [15:0] data_a, data_b;
  tri0 [1:0]  cmd_a, cmd_b;
  logic       busy_a, busy_b;

  assign data_a = drv_data_oe[0] ? drv_data[0] : 16'hzzzz;
  assign data_b = drv_data_oe[1] ? drv_data[1] : 16'hzzzz;
  assign cmd_a  = drv_cmd_oe[0]  ? drv_cmd[0]  : 2'bzz;
  assign cmd_b  = drv_cmd_oe[1]  ? drv_cmd[1]  : 2'bzz;

  mem_ctrl #(.LATENCY(100)) dut (
    .clk (clk), .reset (reset), .mem_address (drv_addr[0]),
    .mem_data (data_a), .mem_command (cmd_a), .busy (busy_a)
  );

  mem_ctrl #(.LATENCY(8)) dut_min (
    .clk (clk), .reset (reset), .mem_address (drv_addr[1]),
    .mem_data (data_b), .mem_command (cmd_b), .busy (busy_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [1:0] obs_cmd(input int sel);
    return (sel != 0) ? cmd_b : cmd_a;
  endfunction

  function automatic logic [15:0] obs_data(input int sel);
    return (sel != 0) ? data_b : data_a;
  endfunction

  function automatic logic obs_busy(input int sel);
    return (sel != 0) ? busy_b : busy_a;
  endfunction

  // Drives a read command for the edge-0 sample, then releases the bus.
  task automatic issue_read(input int sel, input logic [14:0] a);
    drv_addr[sel]   = a;
    drv_cmd[sel]    = C2_READ;
    drv_cmd_oe[sel] = 1'b1;
    @(posedge clk); #1;
    drv_cmd_oe[sel] = 1'b0;
  endtask

  // Streams a full line as 8 beats (edges 0..7), then releases the bus.
  task automatic issue_write(input int sel, input logic [14:0] a, input logic [127:0] line);
    drv_addr[sel]    = a;
    drv_cmd[sel]     = C2_WRITE;
    drv_cmd_oe[sel]  = 1'b1;
    drv_data[sel]    = line[15:0];
    drv_data_oe[sel] = 1'b1;
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1;
      drv_data[sel] = line[16*i +: 16];
    end
    @(posedge clk); #1;
    drv_cmd_oe[sel]  = 1'b0;
    drv_data_oe[sel] = 1'b0;
  endtask

  // Observes the response phase edge by edge; start_e is the number of the next edge.
  // Optionally injects a read command sampled at edge inject_e.
  task automatic collect(input int sel, input int start_e, input int inject_e,
                         input logic [14:0] inject_addr,
                         output int first_e, output int fall_e, output int nbeats,
                         output logic [127:0] line, output logic [1:0] cmd_start,
                         output logic [15:0] data_start, output logic [15:0] data_after);
    int lat;
    lat = (sel != 0) ? 8 : 100;
    first_e = -1; fall_e = -1; nbeats = 0; line = '0;
    cmd_start = 2'bxx; data_start = 16'hxxxx; data_after = 16'hxxxx;
    for (int e = start_e; e <= lat + 40; e++) begin
      @(posedge clk); #1;
      if (e == start_e) begin
        cmd_start  = obs_cmd(sel);
        data_start = obs_data(sel);
      end
      if (obs_busy(sel) === 1'b1 && obs_cmd(sel) === C2_RESPONSE) begin
        if (first_e < 0) first_e = e;
        if (nbeats < 8) line[16*nbeats +: 16] = obs_data(sel);
        nbeats++;
      end
      if (inject_e > 0 && e == inject_e - 1) begin
        drv_addr[sel] = inject_addr; drv_cmd[sel] = C2_READ; drv_cmd_oe[sel] = 1'b1;
      end
      if (inject_e > 0 && e == inject_e) drv_cmd_oe[sel] = 1'b0;
      if (obs_busy(sel) === 1'b0) begin
        fall_e     = e;
        data_after = obs_data(sel);
        break;
      end
    end
  endtask

  logic [127:0] line_l1, line_l3;
  int           first_e, fall_e, nbeats;
  logic [127:0] got_line;
  logic [1:0]   cmd_s;
  logic [15:0]  data_s, data_r;

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a);
    else n_pass++;
    n_checks++;
    if (cmd_a !== CMD_REL) $display("FAIL reset_cmd_released: got %b want %b", cmd_a, CMD_REL);
    else n_pass++;
    n_checks++;
    if (data_a !== DATA_REL) $display("FAIL reset_data_released: got %h want %h", data_a, DATA_REL);
    else n_pass++;
    n_checks++;
    if (busy_b !== 1'b0) $display("FAIL reset_busy_min: got %b want 0", busy_b);
    else n_pass++;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if (busy_a !== 1'b0 || data_a !== DATA_REL)
      $display("FAIL idle_reset: busy %b data %h want 0 / %h", busy_a, data_a, DATA_REL);
    else n_pass++;
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 8; i++) line_l1[16*i +: 16] = {8'(2*i+1), 8'(2*i)};
    issue_write(0, 15'h0012, line_l1);
    collect(0, 8, 0, '0, first_e, fall_e, nbeats, got_line, cmd_s, data_s, data_r);
    n_checks++;
    if (cmd_s !== C2_NOP || data_s !== DATA_REL)
      $display("FAIL wr_wait_bus: cmd %b data %h want 00 / %h", cmd_s, data_s, DATA_REL);
    else n_pass++;
    n_checks++;
    if (first_e !== 100) $display("FAIL wr_resp_edge: got %0d want 100", first_e);
    else n_pass++;
    n_checks++;
    if (nbeats !== 1) $display("FAIL wr_resp_cycles: got %0d want 1", nbeats);
    else n_pass++;
    n_checks++;
    if (fall_e !== 101) $display("FAIL wr_busy_fall: got %0d want 101", fall_e);
    else n_pass++;

    issue_read(0, 15'h0012);
    n_checks++;
    if (busy_a !== 1'b1) $display("FAIL rd_busy_after_cmd: got %b want 1", busy_a);
    else n_pass++;
    collect(0, 1, 0, '0, first_e, fall_e, nbeats, got_line, cmd_s, data_s, data_r);
    n_checks++;
    if (cmd_s !== C2_NOP || data_s !== DATA_REL)
      $display("FAIL rd_wait_bus: cmd %b data %h want 00 / %h", cmd_s, data_s, DATA_REL);
    else n_pass++;
    n_checks++;
    if (first_e !== 100) $display("FAIL rd_resp_edge: got %0d want 100", first_e);
    else n_pass++;
    n_checks++;
    if (nbeats !== 8) $display("FAIL rd_beat_count: got %0d want 8", nbeats);
    else n_pass++;
    n_checks++;
    if (got_line !== line_l1) $display("FAIL rd_after_wr_data: got %h want %h", got_line, line_l1);
    else n_pass++;
    n_checks++;
    if (fall_e !== 108 || data_r !== DATA_REL)
      $display("FAIL rd_release: fall %0d data %h want 108 / %h", fall_e, data_r, DATA_REL);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    issue_read(0, 15'h7FFF);
    n_checks++;
    if (busy_a !== 1'b1) $display("FAIL b2b_accept: got busy %b want 1", busy_a);
    else n_pass++;
    collect(0, 1, 0, '0, first_e, fall_e, nbeats, got_line, cmd_s, data_s, data_r);
    n_checks++;
    if (got_line !== 128'h0 || nbeats !== 8)
      $display("FAIL top_line_zero: got %h beats %0d want 0 / 8", got_line, nbeats);
    else n_pass++;
    n_checks++;
    if (first_e !== 100 || fall_e !== 108)
      $display("FAIL top_line_timing: first %0d fall %0d want 100 / 108", first_e, fall_e);
    else n_pass++;
  endtask

  task automatic test_ignored_cmd();
    issue_read(0, 15'h0012);
    collect(0, 1, 50, 15'h7FFF, first_e, fall_e, nbeats, got_line, cmd_s, data_s, data_r);
    n_checks++;
    if (first_e !== 100 || fall_e !== 108)
      $display("FAIL ignored_timing: first %0d fall %0d want 100 / 108", first_e, fall_e);
    else n_pass++;
    n_checks++;
    if (got_line !== line_l1) $display("FAIL ignored_data: got %h want %h", got_line, line_l1);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (busy_a !== 1'b0) $display("FAIL ignored_no_retrigger: got busy %b want 0", busy_a);
    else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    drv_addr[0]    = 15'h0003;
    drv_cmd[0]     = C2_WRITE;
    drv_cmd_oe[0]  = 1'b1;
    drv_data[0]    = 16'hA000;
    drv_data_oe[0] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      drv_data[0] = 16'hA000 + 16'(i);
    end
    @(posedge clk); #1;
    reset          = 1'b1;
    drv_cmd_oe[0]  = 1'b0;
    drv_data_oe[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if (busy_a !== 1'b0 || cmd_a !== CMD_REL || data_a !== DATA_REL)
      $display("FAIL midwr_reset_release: busy %b cmd %b data %h want 0 / %b / %h",
               busy_a, cmd_a, data_a, CMD_REL, DATA_REL);
    else n_pass++;
    issue_read(0, 15'h0003);
    collect(0, 1, 0, '0, first_e, fall_e, nbeats, got_line, cmd_s, data_s, data_r);
    n_checks++;
    if (got_line !== 128'h0 || nbeats !== 8)
      $display("FAIL midwr_discarded: got %h beats %0d want 0 / 8", got_line, nbeats);
    else n_pass++;
  endtask

  task automatic test_min_latency();
    for (int i = 0; i < 8; i++) line_l3[16*i +: 16] = 16'hC000 + 16'(i * 16'h0111);
    issue_write(1, 15'h0100, line_l3);
    collect(1, 8, 0, '0, first_e, fall_e, nbeats, got_line, cmd_s, data_s, data_r);
    n_checks++;
    if (first_e !== 8 || nbeats !== 1 || fall_e !== 9)
      $display("FAIL min_wr_resp: first %0d cycles %0d fall %0d want 8 / 1 / 9",
               first_e, nbeats, fall_e);
    else n_pass++;
    issue_read(1, 15'h0100);
    collect(1, 1, 0, '0, first_e, fall_e, nbeats, got_line, cmd_s, data_s, data_r);
    n_checks++;
    if (first_e !== 8 || fall_e !== 16)
      $display("FAIL min_rd_timing: first %0d fall %0d want 8 / 16", first_e, fall_e);
    else n_pass++;
    n_checks++;
    if (got_line !== line_l3) $display("FAIL min_rd_data: got %h want %h", got_line, line_l3);
    else n_pass++;
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      drv_addr[s] = '0; drv_cmd[s] = C2_NOP; drv_cmd_oe[s] = 1'b0;
      drv_data[s] = '0; drv_data_oe[s] = 1'b0;
    end
    reset = 1'b1;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_ignored_cmd();
    test_reset_mid_write();
    test_min_latency();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
